// File: rtl/ahb_spi_sequencer.sv
// AHB-Lite master that shares one AHBspi peripheral between two requesters.
// Each accepted job runs select, TX write, status polling and a deselect-all write.
module ahb_spi_sequencer #(
    parameter logic [31:0] SPI_BASE = 32'h0000_0000,
    parameter int          DONE_BIT = 4,
    parameter int          POLL_GAP = 5,
    parameter int          POLL_MAX = 1024
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [1:0][4:0]  req_ss,
    input  logic [1:0][1:0]  req_size,
    input  logic [1:0][31:0] req_data,
    output logic [1:0]       done,
    output logic             err,
    output logic [31:0]      rdata,
    output logic             HSEL_o,
    output logic [31:0]      HADDR_o,
    output logic [1:0]       HTRANS_o,
    output logic             HWRITE_o,
    output logic [2:0]       HSIZE_o,
    output logic [31:0]      HWDATA_o,
    input  logic [31:0]      HRDATA_i,
    input  logic             HREADY_i
);
    localparam int PCW = $clog2(POLL_MAX + 1);
    localparam int GCW = $clog2(POLL_GAP + 1);
    localparam logic [PCW-1:0] POLL_LAST = PCW'(POLL_MAX - 1);
    localparam logic [GCW-1:0] GAP_LAST  = GCW'(POLL_GAP - 1);
    localparam logic [2:0]     SZ_WORD   = 3'b010;

    typedef enum logic [3:0] {
        S_IDLE, S_SEL_A, S_SEL_D, S_TX_A, S_TX_D, S_POLL_A, S_POLL_D,
        S_GAP, S_DESEL_A, S_DESEL_D, S_DONE
    } state_t;

    state_t         state_r, state_s;
    logic           owner_r, last_r, winner_s, accept_s;
    logic [4:0]     ss_r;
    logic [1:0]     size_r;
    logic [31:0]    data_r;
    logic [PCW-1:0] poll_cnt_r;
    logic [GCW-1:0] gap_cnt_r;

    assign accept_s = (state_r == S_IDLE) && (req_valid != 2'b00);

    // Round-robin pick: on a tie the requester not served last wins
    always_comb begin
        winner_s = 1'b0;
        if (req_valid == 2'b11) begin
            winner_s = ~last_r;
        end else if (req_valid[1]) begin
            winner_s = 1'b1;
        end else begin
            winner_s = 1'b0;
        end
    end

    // State register
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next state plus bus and handshake outputs decoded from the current state
    always_comb begin
        state_s   = state_r;
        req_ready = 2'b00;
        done      = 2'b00;
        HTRANS_o  = 2'b00;
        HSEL_o    = 1'b0;
        HADDR_o   = 32'h0;
        HWRITE_o  = 1'b0;
        HSIZE_o   = 3'b000;
        HWDATA_o  = 32'h0;
        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    req_ready = winner_s ? 2'b10 : 2'b01;
                    state_s   = S_SEL_A;
                end else begin
                    state_s   = S_IDLE;
                end
            end
            S_SEL_A: begin
                HTRANS_o = 2'b10;
                HSEL_o   = 1'b1;
                HADDR_o  = SPI_BASE + 32'h4;
                HWRITE_o = 1'b1;
                HSIZE_o  = SZ_WORD;
                state_s  = HREADY_i ? S_SEL_D : S_SEL_A;
            end
            S_SEL_D: begin
                HWDATA_o = ~(32'h1 << ss_r);
                state_s  = HREADY_i ? S_TX_A : S_SEL_D;
            end
            S_TX_A: begin
                HTRANS_o = 2'b10;
                HSEL_o   = 1'b1;
                HADDR_o  = SPI_BASE + 32'h8;
                HWRITE_o = 1'b1;
                HSIZE_o  = (size_r == 2'b11) ? SZ_WORD : {1'b0, size_r};
                state_s  = HREADY_i ? S_TX_D : S_TX_A;
            end
            S_TX_D: begin
                HWDATA_o = data_r;
                state_s  = HREADY_i ? S_POLL_A : S_TX_D;
            end
            S_POLL_A: begin
                HTRANS_o = 2'b10;
                HSEL_o   = 1'b1;
                HADDR_o  = SPI_BASE;
                HSIZE_o  = SZ_WORD;
                state_s  = HREADY_i ? S_POLL_D : S_POLL_A;
            end
            S_POLL_D: begin
                if (!HREADY_i) begin
                    state_s = S_POLL_D;
                end else if (HRDATA_i[DONE_BIT]) begin
                    state_s = S_DESEL_A;
                end else if (poll_cnt_r == POLL_LAST) begin
                    state_s = S_DESEL_A;
                end else begin
                    state_s = S_GAP;
                end
            end
            S_GAP: begin
                state_s = (gap_cnt_r == GAP_LAST) ? S_POLL_A : S_GAP;
            end
            S_DESEL_A: begin
                HTRANS_o = 2'b10;
                HSEL_o   = 1'b1;
                HADDR_o  = SPI_BASE + 32'h4;
                HWRITE_o = 1'b1;
                HSIZE_o  = SZ_WORD;
                state_s  = HREADY_i ? S_DESEL_D : S_DESEL_A;
            end
            S_DESEL_D: begin
                HWDATA_o = 32'hFFFF_FFFF;
                state_s  = HREADY_i ? S_DONE : S_DESEL_D;
            end
            S_DONE: begin
                done    = owner_r ? 2'b10 : 2'b01;
                state_s = S_IDLE;
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // Job latch, arbitration pointer, poll/gap counters and result registers
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            owner_r    <= 1'b0;
            last_r     <= 1'b1;
            ss_r       <= 5'd0;
            size_r     <= 2'd0;
            data_r     <= 32'h0;
            poll_cnt_r <= '0;
            gap_cnt_r  <= '0;
            err        <= 1'b0;
            rdata      <= 32'h0;
        end else begin
            if (accept_s) begin
                owner_r    <= winner_s;
                last_r     <= winner_s;
                ss_r       <= req_ss[winner_s];
                size_r     <= req_size[winner_s];
                data_r     <= req_data[winner_s];
                poll_cnt_r <= '0;
                err        <= 1'b0;
            end
            if (state_r == S_POLL_D && HREADY_i) begin
                rdata      <= HRDATA_i;
                poll_cnt_r <= poll_cnt_r + 1'b1;
                if (!HRDATA_i[DONE_BIT] && poll_cnt_r == POLL_LAST) begin
                    err <= 1'b1;
                end
            end
            // Gap counter restarts on every poll data phase
            if (state_r == S_POLL_D) begin
                gap_cnt_r <= '0;
            end else if (state_r == S_GAP) begin
                gap_cnt_r <= gap_cnt_r + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ahb_spi_sequencer.sv
// Scoreboard bench: the stimulus side predicts bus transfers and job results;
// a negedge monitor plays the AHBspi slave and compares what the DUT does.
module tb_ahb_spi_sequencer;
    localparam logic [31:0] SPI_BASE = 32'h0000_0000;
    localparam int DONE_BIT = 4;
    localparam int POLL_GAP = 5;
    localparam int POLL_MAX = 4;

    logic             HCLK = 1'b0;
    logic             HRESETn = 1'b0;
    logic [1:0]       req_valid = 2'b00;
    logic [1:0]       req_ready;
    logic [1:0][4:0]  req_ss = '0;
    logic [1:0][1:0]  req_size = '0;
    logic [1:0][31:0] req_data = '0;
    logic [1:0]       done;
    logic             err;
    logic [31:0]      rdata;
    logic             HSEL_o;
    logic [31:0]      HADDR_o;
    logic [1:0]       HTRANS_o;
    logic             HWRITE_o;
    logic [2:0]       HSIZE_o;
    logic [31:0]      HWDATA_o;
    logic [31:0]      HRDATA_i = 32'h0;
    logic             HREADY_i = 1'b1;

    ahb_spi_sequencer #(
        .SPI_BASE(SPI_BASE), .DONE_BIT(DONE_BIT), .POLL_GAP(POLL_GAP), .POLL_MAX(POLL_MAX)
    ) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .req_valid(req_valid), .req_ready(req_ready),
        .req_ss(req_ss), .req_size(req_size), .req_data(req_data), .done(done), .err(err),
        .rdata(rdata), .HSEL_o(HSEL_o), .HADDR_o(HADDR_o), .HTRANS_o(HTRANS_o),
        .HWRITE_o(HWRITE_o), .HSIZE_o(HSIZE_o), .HWDATA_o(HWDATA_o), .HRDATA_i(HRDATA_i),
        .HREADY_i(HREADY_i)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] data;
        int          waits;
    } txn_t;

    typedef struct {
        int          owner;
        logic        err;
        logic [31:0] rdata;
        int          lat;
    } job_t;

    txn_t txq[$];
    job_t jobq[$];

    int n_chk = 0;
    int n_pass = 0;

    int          r_ss[2];
    int          r_size[2];
    logic [31:0] r_data[2];
    int          r_ndone[2];
    int          r_txw[2];
    int          last_m = 1;
    bit          rand_waits = 1'b0;
    bit          in_poll_d = 1'b0;
    bit          end_req = 1'b0;
    bit          end_ack = 1'b0;

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic int pick_wait(input int forced);
        if (forced >= 0) return forced;
        if (!rand_waits) return 0;
        return ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
    endfunction

    task automatic push_txn(input logic [31:0] a, input logic w, input logic [2:0] s,
                            input logic [31:0] d, input int wt);
        txn_t t;
        t.addr = a; t.wr = w; t.size = s; t.data = d; t.waits = wt;
        txq.push_back(t);
    endtask

    // Reference model for one job: the bus sequence it must produce and its result
    task automatic model_job(input int o);
        job_t        j;
        int          polls, tot, wv;
        logic [31:0] w, one;
        bit          ok;
        one = 32'h1;
        ok = (r_ndone[o] >= 1) && (r_ndone[o] <= POLL_MAX);
        polls = ok ? r_ndone[o] : POLL_MAX;
        tot = 0;
        w = 32'h0;
        wv = pick_wait(-1); tot += wv;
        push_txn(SPI_BASE + 32'h4, 1'b1, 3'd2, ~(one << r_ss[o]), wv);
        wv = pick_wait(r_txw[o]); tot += wv;
        push_txn(SPI_BASE + 32'h8, 1'b1, (r_size[o] == 3) ? 3'd2 : 3'(r_size[o]), r_data[o], wv);
        for (int k = 0; k < polls; k++) begin
            w = $urandom;
            w[DONE_BIT] = (k == r_ndone[o] - 1);
            wv = pick_wait(-1); tot += wv;
            push_txn(SPI_BASE, 1'b0, 3'd2, w, wv);
        end
        wv = pick_wait(-1); tot += wv;
        push_txn(SPI_BASE + 32'h4, 1'b1, 3'd2, 32'hFFFF_FFFF, wv);
        j.owner = o;
        j.err   = !ok;
        j.rdata = w;
        j.lat   = 9 + (polls - 1) * (2 + POLL_GAP) + tot;
        jobq.push_back(j);
    endtask

    task automatic set_req(input int i, input int ss, input int sz, input logic [31:0] d,
                           input int nd, input int txw);
        r_ss[i] = ss; r_size[i] = sz; r_data[i] = d; r_ndone[i] = nd; r_txw[i] = txw;
        req_ss[i] = 5'(ss); req_size[i] = 2'(sz); req_data[i] = d;
    endtask

    task automatic drive_until_accepted();
        logic [1:0] rdy;
        int guard;
        guard = 0;
        while (req_valid != 2'b00) begin
            @(negedge HCLK); #1;
            rdy = req_ready;
            @(posedge HCLK); #1;
            req_valid = req_valid & ~rdy;
            guard++;
            if (guard > 2000) begin
                $display("FAIL accept_timeout: req_valid %b still pending", req_valid);
                $fatal(1, "request never accepted");
            end
        end
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (jobq.size() != 0) begin
            @(negedge HCLK); #1;
            guard++;
            if (guard > 3000) begin
                $display("FAIL done_timeout: %0d jobs outstanding", jobq.size());
                $fatal(1, "job never completed");
            end
        end
    endtask

    task automatic run_round(input logic [1:0] mask, input bit pulse);
        if (mask == 2'b11) begin
            model_job(1 - last_m);
            model_job(last_m);
        end else begin
            last_m = mask[1] ? 1 : 0;
            model_job(last_m);
        end
        req_valid = mask;
        drive_until_accepted();
        if (pulse) begin
            req_valid = ~mask;
            repeat (2) @(posedge HCLK);
            #1 req_valid = 2'b00;
        end
        wait_idle();
    endtask

    // Slave model and scoreboard monitor
    txn_t        dp;
    bit          dp_pending = 1'b0;
    int          dp_wait = 0;
    int          cyc = 0;
    int          acc_cyc = 0;
    int          done_cyc = 0;
    bit          pend_after_done = 1'b0;
    always @(negedge HCLK or negedge HRESETn) begin
        txn_t        t;
        job_t        j;
        logic [1:0]  exp2;
        if (!HRESETn) begin
            #1;
            chk(done == 2'b00 && err == 1'b0, "rst_done_err", {29'h0, err, done}, 32'h0);
            chk(rdata == 32'h0, "rst_rdata", rdata, 32'h0);
            chk({HSEL_o, HTRANS_o, HWRITE_o, HSIZE_o, req_ready} == 9'h0, "rst_ctrl",
                {23'h0, HSEL_o, HTRANS_o, HWRITE_o, HSIZE_o, req_ready}, 32'h0);
            chk(HADDR_o == 32'h0 && HWDATA_o == 32'h0, "rst_addr_data", HADDR_o | HWDATA_o, 32'h0);
            txq.delete();
            jobq.delete();
            dp_pending = 1'b0;
            HREADY_i = 1'b1;
            in_poll_d = 1'b0;
            pend_after_done = 1'b0;
        end else begin
            cyc++;
            in_poll_d = 1'b0;
            chk(HSEL_o == (HTRANS_o == 2'b10), "hsel_vs_htrans", {30'h0, HTRANS_o}, {31'h0, HSEL_o});
            if (dp_pending) begin
                chk(HTRANS_o == 2'b00, "phase_overlap", {30'h0, HTRANS_o}, 32'h0);
                if (dp.wr) chk(HWDATA_o == dp.data, "hwdata", HWDATA_o, dp.data);
                if (dp_wait > 0) begin
                    HREADY_i = 1'b0;
                    dp_wait--;
                end else begin
                    HREADY_i = 1'b1;
                    dp_pending = 1'b0;
                    in_poll_d = !dp.wr;
                end
            end else begin
                HREADY_i = 1'b1;
            end
            if (HTRANS_o == 2'b10 && HREADY_i) begin
                if (txq.size() == 0) begin
                    chk(1'b0, "unexpected_txn", HADDR_o, 32'h0);
                end else begin
                    t = txq.pop_front();
                    chk(HADDR_o == t.addr, "haddr", HADDR_o, t.addr);
                    chk(HWRITE_o == t.wr, "hwrite", {31'h0, HWRITE_o}, {31'h0, t.wr});
                    chk(HSIZE_o == t.size, "hsize", {29'h0, HSIZE_o}, {29'h0, t.size});
                    dp = t;
                    dp_wait = t.waits;
                    dp_pending = 1'b1;
                    if (!t.wr) HRDATA_i = t.data;
                end
            end
            if (req_ready != 2'b00) begin
                if (jobq.size() == 0) begin
                    chk(1'b0, "unexpected_accept", {30'h0, req_ready}, 32'h0);
                end else begin
                    exp2 = 2'b01 << jobq[0].owner;
                    chk(req_ready == exp2, "accept_winner", {30'h0, req_ready}, {30'h0, exp2});
                end
                if (pend_after_done) begin
                    chk(cyc == done_cyc + 1, "accept_gap", 32'(cyc - done_cyc), 32'd1);
                    pend_after_done = 1'b0;
                end
                acc_cyc = cyc;
            end
            if (done != 2'b00) begin
                if (jobq.size() == 0) begin
                    chk(1'b0, "unexpected_done", {30'h0, done}, 32'h0);
                end else begin
                    j = jobq.pop_front();
                    exp2 = 2'b01 << j.owner;
                    chk(done == exp2, "done_owner", {30'h0, done}, {30'h0, exp2});
                    chk(err == j.err, "err", {31'h0, err}, {31'h0, j.err});
                    chk(rdata == j.rdata, "rdata", rdata, j.rdata);
                    chk(cyc - acc_cyc == j.lat, "done_latency", 32'(cyc - acc_cyc), 32'(j.lat));
                end
                done_cyc = cyc;
                pend_after_done = (req_valid != 2'b00);
            end
            if (end_req && !end_ack) begin
                chk(jobq.size() == 0, "jobs_left", 32'(jobq.size()), 32'h0);
                chk(txq.size() == 0, "txns_left", 32'(txq.size()), 32'h0);
                end_ack = 1'b1;
            end
        end
    end

    initial begin
        logic [1:0] m;
        int guard;
        repeat (3) @(posedge HCLK);
        #1 HRESETn = 1'b1;

        // Tie from reset, then again: requester 0 wins both times
        set_req(0, 3, 2, $urandom, 1, 0);
        set_req(1, 31, 0, $urandom, 1, 0);
        run_round(2'b11, 1'b0);
        set_req(0, 7, 3, $urandom, 1, 0);
        set_req(1, 12, 1, $urandom, 1, 0);
        run_round(2'b11, 1'b0);
        // Plain single job, slow slave, TX wait states, poll timeout
        set_req(0, 0, 1, 32'h0000_1108, 1, 0);
        run_round(2'b01, 1'b1);
        set_req(1, 9, 2, $urandom, 3, 0);
        run_round(2'b10, 1'b0);
        set_req(0, 17, 0, $urandom, 1, 3);
        run_round(2'b01, 1'b0);
        set_req(1, 30, 2, $urandom, 0, 0);
        run_round(2'b10, 1'b0);

        rand_waits = 1'b1;
        for (int n = 0; n < 24; n++) begin
            for (int i = 0; i < 2; i++) begin
                set_req(i, int'($urandom_range(0, 31)), int'($urandom_range(0, 3)), $urandom,
                        int'($urandom_range(0, 5)), -1);
            end
            m = 2'($urandom_range(1, 3));
            run_round(m, (m != 2'b11) && ($urandom_range(0, 1) == 1));
        end

        // Abort a job with reset in POLL_D, then run a fresh job for requester 1
        rand_waits = 1'b0;
        set_req(0, 5, 2, $urandom, 0, 0);
        model_job(0);
        req_valid = 2'b01;
        drive_until_accepted();
        guard = 0;
        while (!in_poll_d) begin
            @(negedge HCLK); #1;
            guard++;
            if (guard > 200) begin
                $display("FAIL poll_d_timeout: never reached a poll data phase");
                $fatal(1, "no poll data phase");
            end
        end
        HRESETn = 1'b0;
        repeat (3) @(posedge HCLK);
        #1 HRESETn = 1'b1;
        last_m = 1;
        set_req(1, 21, 1, $urandom, 2, 0);
        run_round(2'b10, 1'b0);

        end_req = 1'b1;
        guard = 0;
        while (!end_ack && guard < 10) begin
            @(posedge HCLK);
            guard++;
        end
        repeat (2) @(posedge HCLK);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/ahb_spi_sequencer.md
# ahb_spi_sequencer

AHB-Lite master that shares the AHBspi peripheral between two hardware requesters (e.g. display updater and accelerator result writer). It arbitrates round-robin and runs each SPI job as a fixed bus sequence: select slave (0x4), write data (0x8), poll status (0x0) until the done flag, deselect all slaves (0x4). It sits on a private AHB-Lite segment, is the only master there, and drives AHBspi directly.

## Interface
- SPI_BASE, 32'h0000_0000, base address of AHBspi; registers at +0x0 status, +0x4 slave-select, +0x8 TX data
- DONE_BIT, 4, status bit that indicates the transfer has completed
- POLL_GAP, 5, idle cycles between consecutive status polls (≥1)
- POLL_MAX, 1024, poll reads before timeout (≥1)
- HCLK  in  1  bus clock
- HRESETn  in  1  reset, asynchronous, active-low
- req_valid  in  2  per-requester job request, held until ready
- req_ready  out  2  one-hot accept strobe, combinational
- req_ss  in  2x5  slave index 0..31 per requester
- req_size  in  2x2  0 byte, 1 half, 2 word, 3 treated as word
- req_data  in  2x32  TX data, LSB-aligned
- done  out  2  one-cycle completion pulse to owning requester
- err  out  1  valid with done: 1 = poll timeout
- rdata  out  32  last status word read, valid with done
- HSEL_o  out  1  high exactly when HTRANS_o is NONSEQ
- HADDR_o  out  32  address
- HTRANS_o  out  2  IDLE 2'b00 / NONSEQ 2'b10 only
- HWRITE_o  out  1  write
- HSIZE_o  out  3  transfer size
- HWDATA_o  out  32  write data, driven in data phase
- HRDATA_i  in  32  read data
- HREADY_i  in  1  bus ready (slave HREADYOUT)

## Operation
- States: IDLE, SEL_A, SEL_D, TX_A, TX_D, POLL_A, POLL_D, GAP, DESEL_A, DESEL_D, DONE.
- IDLE: if any req_valid, winner = round-robin (pointer `last`; the other requester wins a tie). req_ready[winner]=1 for that cycle; ss/size/data latched; `last`←winner; → SEL_A. Nothing accepted outside IDLE.
- *_A states: NONSEQ, HSEL_o=1; advance only on HREADY_i=1. SEL_A: write WORD at +0x4. TX_A: write at +0x8, HSIZE = latched size (3→WORD). POLL_A: read WORD at +0x0. DESEL_A: write WORD at +0x4.
- *_D states: HTRANS IDLE, HSEL_o=0; hold until HREADY_i=1. SEL_D drives HWDATA_o = ~(32'h1 << ss). TX_D drives data. DESEL_D drives 32'hFFFF_FFFF.
- POLL_D on HREADY_i: capture HRDATA_i into rdata; increment poll counter. If HRDATA_i[DONE_BIT] → DESEL_A. Else if count = POLL_MAX → err←1, DESEL_A. Else → GAP.
- GAP: count POLL_GAP cycles, then POLL_A.
- DONE: done[owner]=1 for one cycle, err/rdata valid; → IDLE; poll counter and err cleared when the next job is accepted.
- Timeout still deselects all slaves.

## Timing
- Reset (async): state IDLE, `last`=1 (so requester 0 wins the first tie), all outputs 0, HTRANS_o IDLE, HSEL_o 0, rdata 0.
- Reset during a job: aborts immediately. No done pulse. AHBspi shares HRESETn, so the slave select returns to its reset state.
- Zero-wait latency: accept edge = cycle 0; SEL_A 1, SEL_D 2, TX_A 3, TX_D 4, POLL_A 5, POLL_D 6, DESEL_A 7, DESEL_D 8, done at cycle 9. The next accept is possible at cycle 10.
- Each not-done poll adds 2+POLL_GAP cycles. Each HREADY_i low cycle extends the current state by one cycle.
- Address and data phases never overlap. Exactly one NONSEQ cycle per transfer unless it is stretched by HREADY_i low.
- req_valid that drops before ready is ignored. No job is lost.

## Test plan
- Single job: req0 ss=0 size=1 data=32'h1108, slave done on first poll → writes 0x4←FFFFFFFE, 0x8←00001108 HSIZE=HALF, 0x4←FFFFFFFF; done[0] at cycle 9, err=0.
- Contention: both valid from reset → req0 served first, then req1 accepted at cycle 10. Then req0 and req1 request together again → req0 wins (last=1).
- Slow slave: done flag appears on 3rd poll, POLL_GAP=5 → done at 9+2·7=23 cycles. rdata[4]=1.
- Wait states: HREADY_i held low 3 cycles during TX_D → all following events shift by 3. HWDATA_o held stable.
- Timeout: POLL_MAX=4, status never done → 4 reads, deselect write, done with err=1.
- Reset asserted in POLL_D → all outputs 0 immediately. No done pulse. After release, a new req1 is accepted and runs normally.
